// File: rtl/axi_settings_bridge_pkg.sv
// ---------------------------------------------------------------------------
// settings_bridge_pkg : shared state encodings and AXI response codes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package settings_bridge_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_STB  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_SAMPLE = 2'd1,
    R_RESP   = 2'd2
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axi_settings_bridge_if.sv
// ---------------------------------------------------------------------------
// axi_settings_bridge_if : AXI4-Lite slave channels plus the settings bus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface axi_settings_bridge_if #(
  parameter int C_DATAWIDTH = 32,
  parameter int C_ADDRWIDTH = 32
);
  logic [C_ADDRWIDTH-1:0]   s_axi_awaddr;
  logic                     s_axi_awvalid;
  logic                     s_axi_awready;
  logic [C_DATAWIDTH-1:0]   s_axi_wdata;
  logic [C_DATAWIDTH/8-1:0] s_axi_wstrb;
  logic                     s_axi_wvalid;
  logic                     s_axi_wready;
  logic [1:0]               s_axi_bresp;
  logic                     s_axi_bvalid;
  logic                     s_axi_bready;

  logic [C_ADDRWIDTH-1:0]   s_axi_araddr;
  logic                     s_axi_arvalid;
  logic                     s_axi_arready;
  logic [C_DATAWIDTH-1:0]   s_axi_rdata;
  logic [1:0]               s_axi_rresp;
  logic                     s_axi_rvalid;
  logic                     s_axi_rready;

  logic [C_DATAWIDTH-1:0]   set_data;
  logic [C_ADDRWIDTH-1:0]   set_addr;
  logic                     set_stb;
  logic [C_ADDRWIDTH-1:0]   get_addr;
  logic [C_DATAWIDTH-1:0]   get_data;

  // Bridge side: AXI slave, settings-bus master
  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, get_data,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output set_data, set_addr, set_stb, get_addr
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, get_data,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  set_data, set_addr, set_stb, get_addr
  );
endinterface

`default_nettype wire

// File: rtl/axi_settings_bridge.sv
// ---------------------------------------------------------------------------
// axi_settings_bridge : AXI4-Lite slave to one-cycle-strobe settings bus
// Optional macro SETTINGS_BRIDGE_STRB_CHECK_EN rejects partial-strobe writes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_settings_bridge
  import settings_bridge_pkg::*;
#(
  parameter int C_DATAWIDTH = 32,
  parameter int C_ADDRWIDTH = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  axi_settings_bridge_if.slave bus
);

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic                   aw_done, w_done, wr_err;
  logic [C_ADDRWIDTH-1:0] awaddr_q, set_addr_q, get_addr_q;
  logic [C_DATAWIDTH-1:0] wdata_q, set_data_q, rdata_q;
  logic                   aw_hs, w_hs, ar_hs, wr_go, strb_bad;

  // Readies are gated by rst_n so every output is low while reset is held
  assign bus.s_axi_awready = rst_n && (wr_state == W_IDLE) && !aw_done;
  assign bus.s_axi_wready  = rst_n && (wr_state == W_IDLE) && !w_done;
  assign bus.s_axi_arready = rst_n && (rd_state == R_IDLE);

  assign aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
  assign w_hs  = bus.s_axi_wvalid  && bus.s_axi_wready;
  assign ar_hs = bus.s_axi_arvalid && bus.s_axi_arready;
  assign wr_go = (wr_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);

`ifdef SETTINGS_BRIDGE_STRB_CHECK_EN
  logic [C_DATAWIDTH/8-1:0] wstrb_q;
  logic [C_DATAWIDTH/8-1:0] wstrb_sel;

  assign wstrb_sel = w_hs ? bus.s_axi_wstrb : wstrb_q;
  assign strb_bad  = ~&wstrb_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstrb_q <= '0;
    end else if (w_hs) begin
      wstrb_q <= bus.s_axi_wstrb;
    end
  end
`else
  logic wstrb_unused;
  assign wstrb_unused = ^bus.s_axi_wstrb;
  assign strb_bad     = 1'b0;
`endif

  // Write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state   <= W_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      set_addr_q <= '0;
      set_data_q <= '0;
      wr_err     <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      if (aw_hs) begin
        aw_done  <= 1'b1;
        awaddr_q <= bus.s_axi_awaddr;
      end
      if (w_hs) begin
        w_done  <= 1'b1;
        wdata_q <= bus.s_axi_wdata;
      end
      // Launch takes the live bus value when the last handshake is this cycle
      if (wr_go) begin
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        set_addr_q <= aw_hs ? bus.s_axi_awaddr : awaddr_q;
        set_data_q <= w_hs  ? bus.s_axi_wdata  : wdata_q;
        wr_err     <= strb_bad;
      end
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    unique case (wr_state)
      W_IDLE:  if (wr_go) wr_state_nxt = W_STB;
      W_STB:   wr_state_nxt = W_RESP;
      W_RESP:  if (bus.s_axi_bready) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  assign bus.set_stb      = (wr_state == W_STB) && !wr_err;
  assign bus.set_addr     = set_addr_q;
  assign bus.set_data     = set_data_q;
  assign bus.s_axi_bvalid = (wr_state == W_RESP);
  assign bus.s_axi_bresp  = ((wr_state == W_RESP) && wr_err) ? RESP_SLVERR : RESP_OKAY;

  // Read FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state   <= R_IDLE;
      get_addr_q <= '0;
      rdata_q    <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (ar_hs) begin
        get_addr_q <= bus.s_axi_araddr;
      end
      if (rd_state == R_SAMPLE) begin
        rdata_q <= bus.get_data;
      end
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      R_IDLE:   if (ar_hs) rd_state_nxt = R_SAMPLE;
      R_SAMPLE: rd_state_nxt = R_RESP;
      R_RESP:   if (bus.s_axi_rready) rd_state_nxt = R_IDLE;
      default:  rd_state_nxt = R_IDLE;
    endcase
  end

  assign bus.get_addr     = get_addr_q;
  assign bus.s_axi_rdata  = rdata_q;
  assign bus.s_axi_rvalid = (rd_state == R_RESP);
  assign bus.s_axi_rresp  = RESP_OKAY;

endmodule

`default_nettype wire
